// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Sits behind a start-bit detector. Once the detector reports that the
//   centre of a start bit has been reached, this block:
//     - samples the serial line at the centre of every data bit, LSB first;
//     - samples and checks the stop bit;
//     - spends one cycle pulsing the detector clear so the next frame can
//       be detected.
//   Bit centres are located with a free-running bit-period counter. The
//   counter starts from the start-bit centre, so every later sample also
//   lands on a bit centre.
//
// Ports
//   clk_i                 single clock, rising-edge active
//   rst_i                 synchronous active-high reset
//   data_i                serial line, already synchronised, idles high
//   start_bit_detected_i  level from the detector, high once a start centre is seen
//   data_out_o            last good data word (LSB = first received bit)
//   data_valid_o          one-cycle pulse, data_out_o was just loaded
//   framing_error_o       one-cycle pulse, the stop bit was sampled low
//   detector_clear_o      one-cycle pulse, to be ORed into the detector reset
//   busy_o                high whenever the framer is not idle
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_i,
  input  logic                 start_bit_detected_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  output logic                 framing_error_o,
  output logic                 detector_clear_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    CLEAR
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       bitCnt_q;
  logic [IDX_W-1:0]       bitIdx_q;
  logic [DATA_BITS-1:0]   shiftReg_q;
  logic [DATA_BITS-1:0]   dataOut_q;
  logic                   dataValid_q;
  logic                   framingError_q;
  logic                   detectorClear_q;
  logic                   busy_q;
  logic                   sampleEdge;

  // A sampling edge is the last count of a bit period. The counter is
  // cleared on the start-bit centre, so this edge is the next bit centre.
  always_comb begin
    sampleEdge = (bitCnt_q == CNT_LAST);
  end

  // Framer state machine. Every output is a register. The pulse outputs
  // default low each cycle, and only the STOP->CLEAR transition raises them,
  // so each pulse lasts exactly the single CLEAR cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      bitCnt_q        <= '0;
      bitIdx_q        <= '0;
      shiftReg_q      <= '0;
      dataOut_q       <= '0;
      dataValid_q     <= 1'b0;
      framingError_q  <= 1'b0;
      detectorClear_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      dataValid_q     <= 1'b0;
      framingError_q  <= 1'b0;
      detectorClear_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_bit_detected_i) begin
            state_q  <= DATA;
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            busy_q   <= 1'b1;
          end
        end

        DATA: begin
          if (sampleEdge) begin
            bitCnt_q   <= '0;
            // Shift right so the first received bit ends up in bit 0.
            shiftReg_q <= {data_i, shiftReg_q[DATA_BITS-1:1]};
            if (bitIdx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + IDX_W'(1);
            end
          end else begin
            bitCnt_q <= bitCnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (sampleEdge) begin
            bitCnt_q        <= '0;
            state_q         <= CLEAR;
            detectorClear_q <= 1'b1;
            if (data_i) begin
              dataOut_q   <= shiftReg_q;
              dataValid_q <= 1'b1;
            end else begin
              framingError_q <= 1'b1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + CNT_W'(1);
          end
        end

        CLEAR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o       = dataOut_q;
  assign data_valid_o     = dataValid_q;
  assign framing_error_o  = framingError_q;
  assign detector_clear_o = detectorClear_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer
//   Directed bench for uart_rx_framer. Instance dutA uses the default
//   parameters (8 clocks per bit, 8 data bits). Instance dutB uses 2 clocks
//   per bit and 5 data bits. Inputs change on the falling edge, and outputs
//   are observed on the falling edge that follows each rising edge.
module tb_uart_rx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       rstA, dataA, startA;
  logic [7:0] doutA;
  logic       dvA, feA, dcA, busyA;

  // Small-parameter instance.
  logic       rstB, dataB, startB;
  logic [4:0] doutB;
  logic       dvB, feB, dcB, busyB;

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_framer dutA (
    .clk_i                (clk),
    .rst_i                (rstA),
    .data_i               (dataA),
    .start_bit_detected_i (startA),
    .data_out_o           (doutA),
    .data_valid_o         (dvA),
    .framing_error_o      (feA),
    .detector_clear_o     (dcA),
    .busy_o               (busyA)
  );

  uart_rx_framer #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dutB (
    .clk_i                (clk),
    .rst_i                (rstB),
    .data_i               (dataB),
    .start_bit_detected_i (startB),
    .data_out_o           (doutB),
    .data_valid_o         (dvB),
    .framing_error_o      (feB),
    .detector_clear_o     (dcB),
    .busy_o               (busyB)
  );

  task automatic applyStimulus(input logic rstV, input logic startV, input logic dataV);
    rstA   = rstV;
    startA = startV;
    dataA  = dataV;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Checks every dutA output for the cycle that follows rising edge e of a
  // frame, where edge 0 is the edge that sees the start request.
  task automatic checkFrameCycleA(input int e, input logic stopBit,
                                  input logic [7:0] word, input logic [7:0] prevOut);
    checkOutput($sformatf("busyA@%0d", e), {7'd0, busyA}, {7'd0, (e <= 72)});
    checkOutput($sformatf("validA@%0d", e), {7'd0, dvA}, {7'd0, (e == 72 && stopBit)});
    checkOutput($sformatf("ferrA@%0d", e), {7'd0, feA}, {7'd0, (e == 72 && !stopBit)});
    checkOutput($sformatf("clearA@%0d", e), {7'd0, dcA}, {7'd0, (e == 72)});
    checkOutput($sformatf("doutA@%0d", e), doutA, (e >= 72 && stopBit) ? word : prevOut);
  endtask

  // Sends one frame to dutA. Call it just after a falling edge while dutA is
  // idle. Bit k is held on the line for the bit period that ends at its
  // centre, edge 8*(k+1); the stop bit's period ends at edge 72. With glitch
  // set, every non-centre cycle carries the inverted value instead. With
  // holdStart set, start stays high for the whole frame.
  task automatic frameA(input logic [7:0] word, input logic stopBit, input bit glitch,
                        input bit holdStart, input logic [7:0] prevOut);
    logic val;
    int   b;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int t = 1; t <= 74; t++) begin
      @(negedge clk);
      checkFrameCycleA(t - 1, stopBit, word, prevOut);
      b = (t - 1) / 8;
      if (b < 8)       val = word[b];
      else if (b == 8) val = stopBit;
      else             val = 1'b1;
      if (glitch && (t % 8 != 0)) val = ~val;
      applyStimulus(1'b0, holdStart ? 1'b1 : 1'b0, val);
    end
  endtask

  task automatic idleA(input int n);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idleBusyA", {7'd0, busyA}, 8'd0);
      checkOutput("idleClearA", {7'd0, dcA}, 8'd0);
    end
  endtask

  initial begin
    logic [7:0] abortWord;
    logic [4:0] wordB;
    int         b;

    // Power-on reset on both instances.
    applyStimulus(1'b1, 1'b0, 1'b1);
    rstB = 1'b1; startB = 1'b0; dataB = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstDoutA", doutA, 8'h00);
    checkOutput("rstValidA", {7'd0, dvA}, 8'd0);
    checkOutput("rstFerrA", {7'd0, feA}, 8'd0);
    checkOutput("rstClearA", {7'd0, dcA}, 8'd0);
    checkOutput("rstBusyA", {7'd0, busyA}, 8'd0);
    idleA(2);

    $display("[TB] good frame 0xA5");
    frameA(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
    idleA(3);

    $display("[TB] framing error on 0x3C");
    frameA(8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5);
    idleA(3);

    $display("[TB] glitching line around centres of 0x81");
    frameA(8'h81, 1'b1, 1'b1, 1'b0, 8'hA5);
    idleA(3);

    $display("[TB] back-to-back 0x00 then 0xFF");
    frameA(8'h00, 1'b1, 1'b0, 1'b1, 8'h81);
    frameA(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    idleA(3);

    // Reset pulse arrives at edge 30, in the middle of a frame.
    $display("[TB] reset mid-frame");
    abortWord = 8'h6B;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      checkOutput("abortBusyA", {7'd0, busyA}, 8'd1);
      checkOutput("abortValidA", {7'd0, dvA}, 8'd0);
      b = (t - 1) / 8;
      applyStimulus((t == 30) ? 1'b1 : 1'b0, 1'b0, abortWord[b]);
    end
    @(negedge clk);
    checkOutput("abortRstBusyA", {7'd0, busyA}, 8'd0);
    checkOutput("abortRstDoutA", doutA, 8'h00);
    checkOutput("abortRstValidA", {7'd0, dvA}, 8'd0);
    checkOutput("abortRstFerrA", {7'd0, feA}, 8'd0);
    checkOutput("abortRstClearA", {7'd0, dcA}, 8'd0);
    idleA(4);
    frameA(8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
    idleA(2);

    // Start requests must be ignored while reset is held.
    $display("[TB] small instance, start under reset");
    rstB = 1'b1; startB = 1'b1; dataB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("heldRstBusyB", {7'd0, busyB}, 8'd0);
      checkOutput("heldRstValidB", {7'd0, dvB}, 8'd0);
      checkOutput("heldRstFerrB", {7'd0, feB}, 8'd0);
      checkOutput("heldRstClearB", {7'd0, dcB}, 8'd0);
      checkOutput("heldRstDoutB", {3'd0, doutB}, 8'h00);
    end

    // The first edge after reset is released is edge 0 of frame 0x15.
    $display("[TB] small instance frame 0x15");
    wordB = 5'h15;
    rstB = 1'b0; startB = 1'b1; dataB = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      checkOutput($sformatf("busyB@%0d", t - 1), {7'd0, busyB}, {7'd0, (t - 1 <= 12)});
      checkOutput($sformatf("validB@%0d", t - 1), {7'd0, dvB}, {7'd0, (t - 1 == 12)});
      checkOutput($sformatf("ferrB@%0d", t - 1), {7'd0, feB}, 8'd0);
      checkOutput($sformatf("clearB@%0d", t - 1), {7'd0, dcB}, {7'd0, (t - 1 == 12)});
      checkOutput($sformatf("doutB@%0d", t - 1), {3'd0, doutB}, (t - 1 >= 12) ? 8'h15 : 8'h00);
      b = (t - 1) / 2;
      startB = 1'b0;
      if (b < 5) dataB = wordB[b];
      else       dataB = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Purpose: downstream of start_bit_detector. Once a start bit is flagged, sample the serial line at each bit centre, assemble the data word, check the stop bit, then clear the detector for the next frame.

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, meaning clk cycles per UART bit period (oversampling ratio); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data  input  1  serial line, already synchronized to clk; idle high.
REQ-006 start_bit_detected  input  1  level from start_bit_detector; high means a start bit centre has been reached; stays high until the detector is reset.
REQ-007 data_out  output  DATA_BITS  last correctly framed data word, LSB = first received bit.
REQ-008 data_valid  output  1  one-cycle pulse: data_out was just updated with a good frame.
REQ-009 framing_error  output  1  one-cycle pulse: the stop bit was sampled low.
REQ-010 detector_clear  output  1  one-cycle pulse; integrator ORs it into the detector's rst.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, DATA, STOP and CLEAR.
REQ-013 In IDLE, start_bit_detected sampled high at edge t=0 SHALL move to DATA, clear the bit-period counter and clear the bit index.
REQ-014 In DATA and STOP, the bit-period counter SHALL increment every cycle and wrap to 0 after reaching CLKS_PER_BIT-1.
REQ-015 The sampling edge SHALL be each edge where the counter equals CLKS_PER_BIT-1.
REQ-016 Data bit k (k=0..DATA_BITS-1) SHALL be sampled at edge t=(k+1)*CLKS_PER_BIT, LSB first, into an internal shift register.
REQ-017 On the sampling edge of bit DATA_BITS-1, the FSM SHALL move to STOP.
REQ-018 The stop bit SHALL be sampled at edge t=(DATA_BITS+1)*CLKS_PER_BIT, and on that edge the FSM SHALL move to CLEAR.
REQ-019 If the stop bit is 1, data_out SHALL load the shift register and data_valid SHALL be high for the single CLEAR cycle.
REQ-020 If the stop bit is 0, data_out SHALL keep its old value and framing_error SHALL be high for the single CLEAR cycle.
REQ-021 detector_clear SHALL be high exactly during the CLEAR cycle; CLEAR SHALL last one cycle and then go to IDLE.
REQ-022 data_valid and framing_error SHALL never both be high in the same cycle.
REQ-023 start_bit_detected SHALL be ignored in DATA, STOP and CLEAR.
REQ-024 In the first IDLE cycle after CLEAR, the detector has been reset, so start_bit_detected is low; if it is high anyway, the framer SHALL start a new frame (REQ-013 applies).
REQ-025 Changes on data between sampling edges SHALL have no effect.
REQ-026 data_out SHALL hold its value indefinitely between good frames.
REQ-027 For DATA_BITS<8, only data_out[DATA_BITS-1:0] exists, since the port width equals DATA_BITS.
REQ-028 Outputs data_valid, framing_error, detector_clear and busy SHALL be registered, with no combinational path from inputs.
REQ-029 Latency from start_bit_detected sampled at t=0 to the data_valid cycle SHALL be (DATA_BITS+1)*CLKS_PER_BIT cycles (defaults: 72).

Reset
REQ-030 While rst is high at an edge, the FSM SHALL go to IDLE; the counter, bit index, shift register and data_out SHALL go to 0; data_valid, framing_error, detector_clear and busy SHALL go to 0.
REQ-031 rst SHALL take priority over every other input, including start_bit_detected and a pending sampling edge.
REQ-032 rst asserted mid-frame SHALL abort the frame with no data_valid, framing_error or detector_clear pulse.
REQ-033 After rst is released, the framer SHALL act on start_bit_detected from the first following edge.

Verification (CLKS_PER_BIT=8, DATA_BITS=8 unless noted)
REQ-034 Good frame: start_bit_detected high at t=0, bit centres carry 0xA5 LSB first, stop=1 -> data_out=0xA5 with data_valid and detector_clear high only at t=72..73 and framing_error always 0.
REQ-035 Framing error: as REQ-034 with 0x3C and stop=0 -> framing_error and detector_clear one-cycle pulse, data_valid 0, data_out keeps 0xA5.
REQ-036 Glitch immunity: toggle data on every non-sampling cycle while centres carry 0x81 -> data_out=0x81.
REQ-037 Back-to-back: start_bit_detected held high through the whole frame and re-asserted in the first IDLE cycle -> two consecutive frames 0x00 then 0xFF, each with exactly one data_valid.
REQ-038 Reset mid-frame: rst at t=30 for one cycle -> busy=0 and data_out=0 on the next cycle, no pulses; the next frame 0x5A is received correctly.
REQ-039 Parameter sweep: CLKS_PER_BIT=2 with DATA_BITS=5 sends 0x15 -> data_valid at t=12 with data_out=5'h15; while rst is held, start_bit_detected has no effect and all outputs stay 0.
